// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// default frame geometry, line levels and the one-hot FSM state encoding.
package uart_pkg;

  localparam int NB_DATA_DFLT = 8;
  localparam int SB_TICK_DFLT = 16;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  typedef enum logic [4:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so a reset never looks like a line transition.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: LSB-first, idle-high line, mid-bit sampling on the shared oversample tick.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (o_parity_err).
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT,
  parameter int SB_TICK = SB_TICK_DFLT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output logic               o_busy
);

  localparam int TW = $clog2(SB_TICK);
  localparam int BW = $clog2(NB_DATA + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(SB_TICK / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

  logic               rx_s;
  logic               rx_prev;
  logic               fall;
  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`endif

  uart_sync #(
    .RST_VAL (LINE_IDLE)
  ) u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .async_in (i_rx_data),
    .sync_out (rx_s)
  );

  // Only a genuine high-to-low transition starts a frame; a line held low never re-arms.
  assign fall   = (rx_prev == LINE_IDLE) && (rx_s == START_BIT);
  assign o_busy = (state != IDLE);

  // The shift register carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_tick && (state == DATA) && (tick_cnt == BIT_LAST)) begin
      shreg <= {rx_s, shreg[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_prev      <= LINE_IDLE;
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      rx_prev      <= rx_s;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        // A tick coinciding with the start edge is deliberately dropped.
        IDLE: begin
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (i_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (rx_s == START_BIT) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        DATA: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif

        // Returning to IDLE at stop mid-bit leaves half a bit to catch the next start edge.
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s != LINE_IDLE) begin
                o_frame_err <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              else if (^{shreg, par_bit}) begin
                o_parity_err <= 1'b1;
              end
`endif
              else begin
                o_data  <= shreg;
                o_valid <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
